// File: rtl/seg_scan_decoder_if.sv
// Seven-segment scan bus bundle.
// Master drives the scan lines, slave returns the decoded digits.
interface seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 6
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS-1:0]   anodes;
  logic [7:0]              dispBits;
  logic                    clrErr;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dots;
  logic [NUM_DIGITS-1:0]   digitValid;
  logic                    updStrobe;
  logic [IW-1:0]           updIndex;
  logic                    errFlag;

  modport master (
    output anodes,
    output dispBits,
    output clrErr,
    input  digits,
    input  dots,
    input  digitValid,
    input  updStrobe,
    input  updIndex,
    input  errFlag
  );

  modport slave (
    input  anodes,
    input  dispBits,
    input  clrErr,
    output digits,
    output dots,
    output digitValid,
    output updStrobe,
    output updIndex,
    output errFlag
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 7-segment scan and rebuilds the digit values.
// A digit is captured once its pattern has been steady long enough.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  seg_scan_decoder_if.slave bus
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = NUM_DIGITS + 8;
  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] RUN_ARM = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0] live;
  logic [SW-1:0] samp;
  logic [SW-1:0] prev;
  logic [7:0]    run;
  logic [7:0]    run_nxt;
  logic          sel;
  logic          same;
  logic          hold;
  logic          fire;
  logic [IW-1:0] idx;
  logic [3:0]    val;
  logic          bad;

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dots_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic                    strobe_q;
  logic [IW-1:0]           idx_q;
  logic                    err_q;

  assign live = {bus.anodes, bus.dispBits};

  // Exactly one active-low anode means a single digit is being driven.
  assign sel  = ($countones(~samp[SW-1:8]) == 1);
  assign same = (samp == prev);
  assign hold = (live == samp);

  // The live bus must still agree with the armed sample, so a pattern
  // has to be seen on STABLE_CYCLES+1 consecutive edges to be taken.
  assign fire = sel && same && hold && (run == RUN_ARM);

  // Run length of identical selecting samples, saturating.
  always_comb begin
    run_nxt = run;
    if (!sel) begin
      run_nxt = 8'd0;
    end else if (!same) begin
      run_nxt = 8'd1;
    end else if (run != RUN_MAX) begin
      run_nxt = run + 8'd1;
    end
  end

  // Position of the single low anode in the held sample.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!samp[8+i]) begin
        idx = IW'(i);
      end
    end
  end

  // Segment pattern to digit value; unknown shapes become Eh.
  always_comb begin
    val = 4'hE;
    bad = 1'b0;
    case (samp[6:0])
      7'h40:   val = 4'h0;
      7'h79:   val = 4'h1;
      7'h24:   val = 4'h2;
      7'h30:   val = 4'h3;
      7'h19:   val = 4'h4;
      7'h12:   val = 4'h5;
      7'h02:   val = 4'h6;
      7'h78:   val = 4'h7;
      7'h00:   val = 4'h8;
      7'h10:   val = 4'h9;
      7'h7F:   val = 4'hF;
      default: bad = 1'b1;
    endcase
  end

  // Sample pipeline and run counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp <= '1;
      prev <= '1;
      run  <= '0;
    end else begin
      samp <= live;
      prev <= samp;
      run  <= run_nxt;
    end
  end

  // Registered digit store, strobe, index and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q <= '1;
      dots_q   <= '0;
      valid_q  <= '0;
      strobe_q <= 1'b0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      strobe_q <= fire;
      if (fire) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (idx == IW'(i)) begin
            digits_q[4*i +: 4] <= val;
            dots_q[i]          <= ~samp[7];
            valid_q[i]         <= 1'b1;
          end
        end
        idx_q <= idx;
      end
      if (fire && bad) begin
        err_q <= 1'b1;
      end else if (bus.clrErr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.digits     = digits_q;
  assign bus.dots       = dots_q;
  assign bus.digitValid = valid_q;
  assign bus.updStrobe  = strobe_q;
  assign bus.updIndex   = idx_q;
  assign bus.errFlag    = err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed cases then random scan traffic.
// Expected values come from a run-length model of the scan rules.
module tb_seg_scan_decoder;
  localparam int ND = 6;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_decoder #(
    .NUM_DIGITS(ND),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int nstrobe = 0;

  logic [6:0] pats [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};
  logic [3:0] vals [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                            4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF};

  logic [ND+7:0]   prev_s;
  int              runlen;
  logic [4*ND-1:0] e_dig;
  logic [ND-1:0]   e_dot;
  logic [ND-1:0]   e_val;
  logic            e_strobe;
  logic [2:0]      e_idx;
  logic            e_err;

  function automatic logic [4:0] decode(input logic [6:0] s);
    for (int v = 0; v < 11; v++) begin
      if (pats[v] == s) return {1'b0, vals[v]};
    end
    return {1'b1, 4'hE};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prev_s   = '1;
    runlen   = 0;
    e_dig    = '1;
    e_dot    = '0;
    e_val    = '0;
    e_strobe = 1'b0;
    e_idx    = '0;
    e_err    = 1'b0;
  endtask

  task automatic model_edge(input logic [ND-1:0] an, input logic [7:0] db,
                            input logic clr);
    logic [ND+7:0] cur;
    logic [4:0] d;
    int z;
    int k;
    cur = {an, db};
    z = 0;
    k = 0;
    d = '0;
    for (int i = 0; i < ND; i++) begin
      if (!an[i]) begin
        z++;
        k = i;
      end
    end
    if (z != 1) runlen = 0;
    else if (cur == prev_s && runlen > 0) runlen++;
    else runlen = 1;
    e_strobe = (runlen == SC + 1);
    if (e_strobe) begin
      d = decode(db[6:0]);
      e_dig[4*k +: 4] = d[3:0];
      e_dot[k] = ~db[7];
      e_val[k] = 1'b1;
      e_idx = 3'(k);
    end
    if (e_strobe && d[4]) e_err = 1'b1;
    else if (clr) e_err = 1'b0;
    prev_s = cur;
  endtask

  task automatic check_all();
    check("strobe", 32'(bus.updStrobe), 32'(e_strobe));
    check("index", 32'(bus.updIndex), 32'(e_idx));
    check("err", 32'(bus.errFlag), 32'(e_err));
    check("digits", 32'(bus.digits), 32'(e_dig));
    check("dots", 32'(bus.dots), 32'(e_dot));
    check("valid", 32'(bus.digitValid), 32'(e_val));
  endtask

  task automatic check_reset_vals();
    check("rst_digits", 32'(bus.digits), 32'h00FF_FFFF);
    check("rst_dots", 32'(bus.dots), 32'h0);
    check("rst_valid", 32'(bus.digitValid), 32'h0);
    check("rst_strobe", 32'(bus.updStrobe), 32'h0);
    check("rst_index", 32'(bus.updIndex), 32'h0);
    check("rst_err", 32'(bus.errFlag), 32'h0);
  endtask

  // Called just after an active edge; drives, waits one edge, checks.
  task automatic step(input logic [ND-1:0] an, input logic [7:0] db,
                      input logic clr);
    bus.anodes   = an;
    bus.dispBits = db;
    bus.clrErr   = clr;
    @(posedge clk);
    model_edge(an, db, clr);
    #1;
    if (bus.updStrobe) nstrobe++;
    check_all();
  endtask

  task automatic hold(input logic [ND-1:0] an, input logic [7:0] db,
                      input int n);
    for (int i = 0; i < n; i++) step(an, db, 1'b0);
  endtask

  initial begin
    logic [ND-1:0] an;
    logic [7:0] db;
    int r;
    bus.anodes   = '1;
    bus.dispBits = '1;
    bus.clrErr   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;

    // steady "1" on digit 0: one capture on the fifth edge
    nstrobe = 0;
    hold(6'b111110, 8'hF9, 8);
    check("r26_strobes", 32'(nstrobe), 32'd1);
    check("r26_dig0", 32'(bus.digits[3:0]), 32'h1);
    check("r26_valid", 32'(bus.digitValid), 32'b000001);

    // four-edge holds are too short
    nstrobe = 0;
    hold(6'b111011, 8'h12, 4);
    hold(6'b110111, 8'hC0, 4);
    check("r27_short", 32'(nstrobe), 32'd0);
    hold(6'b111011, 8'h12, 5);
    hold(6'b110111, 8'hC0, 5);
    check("r27_long", 32'(nstrobe), 32'd2);
    check("r27_dig2", 32'(bus.digits[11:8]), 32'h5);
    check("r27_dot2", 32'(bus.dots[2]), 32'h1);
    check("r27_dig3", 32'(bus.digits[15:12]), 32'h0);
    check("r27_dot3", 32'(bus.dots[3]), 32'h0);

    // a one-edge glitch restarts the run
    nstrobe = 0;
    hold(6'b111101, 8'h24, 3);
    hold(6'b111101, 8'h30, 1);
    hold(6'b111101, 8'h24, 4);
    check("r28_early", 32'(nstrobe), 32'd0);
    hold(6'b111101, 8'h24, 1);
    check("r28_cap", 32'(bus.updStrobe), 32'h1);
    check("r28_dig1", 32'(bus.digits[7:4]), 32'h2);

    // two anodes low never select; blank decodes to Fh
    nstrobe = 0;
    hold(6'b111100, 8'h40, 10);
    check("r29_multi", 32'(nstrobe), 32'd0);
    hold(6'b011111, 8'hFF, 5);
    check("r29_dig5", 32'(bus.digits[23:20]), 32'hF);
    check("r29_valid5", 32'(bus.digitValid[5]), 32'h1);
    check("r29_err", 32'(bus.errFlag), 32'h0);

    // invalid shape, clear, then clear colliding with a new error
    hold(6'b111110, 8'hFE, 5);
    check("r30_dig0", 32'(bus.digits[3:0]), 32'hE);
    check("r30_set", 32'(bus.errFlag), 32'h1);
    step(6'b111111, 8'hFF, 1'b1);
    check("r30_clr", 32'(bus.errFlag), 32'h0);
    hold(6'b111110, 8'hFE, 4);
    step(6'b111110, 8'hFE, 1'b1);
    check("r30_setwins", 32'(bus.errFlag), 32'h1);

    // reset in the middle of a run discards it
    hold(6'b101111, 8'h79, 3);
    reset = 1'b1;
    #1;
    check_reset_vals();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    nstrobe = 0;
    hold(6'b101111, 8'h79, 4);
    check("r31_early", 32'(nstrobe), 32'd0);
    hold(6'b101111, 8'h79, 1);
    check("r31_cap", 32'(bus.updStrobe), 32'h1);
    check("r31_dig4", 32'(bus.digits[19:16]), 32'h1);

    // random scan traffic
    for (int s = 0; s < 60; s++) begin
      r = int'($urandom_range(0, 9));
      an = '1;
      if (r < 7) an[$urandom_range(0, ND-1)] = 1'b0;
      else if (r == 8) an = ND'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        db[6:0] = pats[$urandom_range(0, 10)];
        db[7] = 1'($urandom);
      end else begin
        db = 8'($urandom);
      end
      r = int'($urandom_range(1, 8));
      for (int j = 0; j < r; j++) begin
        step(an, db, ($urandom_range(0, 7) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
